// File: rtl/adder_share_arbiter_pkg.sv
// Shared types and helpers for the adder-sharing arbiter: FSM encoding,
// default operand width and pointer-width arithmetic.
package adder_share_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < n) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/adder_share_arbiter_if.sv
// Requester, response and external-adder signals of the arbiter, with the
// arbiter (slave) and surrounding-logic (master) views.
interface adder_share_arbiter_if
  import adder_share_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int N_REQ = 2
);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]       rsp_result;
  logic [WIDTH-1:0]       add_a;
  logic [WIDTH-1:0]       add_b;
  logic [WIDTH-1:0]       add_result;

  modport slave (
    input  req, req_a, req_b, add_result,
    output gnt, rsp_valid, rsp_result, add_a, add_b
  );

  modport master (
    output req, req_a, req_b, add_result,
    input  gnt, rsp_valid, rsp_result, add_a, add_b
  );

endinterface

// File: rtl/adder_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping from N-1 back to 0.
module rr_pick #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] winner,
  output logic          any
);

  logic [N-1:0]  grant_s;
  logic [PW-1:0] winner_s;
  logic          any_s;

  // Scan requesters in rotated order starting at ptr; first hit wins.
  always_comb begin
    grant_s  = '0;
    winner_s = '0;
    any_s    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any_s && req[(int'(ptr) + i) % N]) begin
        any_s    = 1'b1;
        winner_s = PW'((int'(ptr) + i) % N);
      end else begin
        any_s = any_s;
      end
    end
    if (any_s) begin
      grant_s[winner_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
  end

  assign grant  = grant_s;
  assign winner = winner_s;
  assign any    = any_s;

endmodule

// File: rtl/adder_share_arbiter.sv
// Time-shares one external combinational adder between N_REQ requesters:
// round-robin grant in IDLE, operand capture, result capture, response pulse.
module adder_share_arbiter
  import adder_share_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int N_REQ = 2
) (
  input logic                   clk,
  input logic                   reset,
  adder_share_arbiter_if.slave  bus
);

  localparam int PW = (clog2(N_REQ) > 0) ? clog2(N_REQ) : 1;

  state_e             state_r;
  logic [PW-1:0]      rr_ptr_r;
  logic [PW-1:0]      owner_r;
  logic [PW-1:0]      next_ptr_s;
  logic [PW-1:0]      winner_s;
  logic [N_REQ-1:0]   pick_grant_s;
  logic [N_REQ-1:0]   gnt_s;
  logic [N_REQ-1:0]   rsp_valid_r;
  logic               any_s;
  logic [WIDTH-1:0]   op_a_r;
  logic [WIDTH-1:0]   op_b_r;
  logic [WIDTH-1:0]   rsp_result_r;
  logic [WIDTH-1:0]   sel_a_s;
  logic [WIDTH-1:0]   sel_b_s;

  rr_pick #(
    .N  (N_REQ),
    .PW (PW)
  ) u_pick (
    .req    (bus.req),
    .ptr    (rr_ptr_r),
    .grant  (pick_grant_s),
    .winner (winner_s),
    .any    (any_s)
  );

  // Operand slices of the current round-robin winner.
  always_comb begin
    sel_a_s = bus.req_a[int'(winner_s) * WIDTH +: WIDTH];
    sel_b_s = bus.req_b[int'(winner_s) * WIDTH +: WIDTH];
  end

  // Grant is only offered from IDLE and is suppressed while reset is held.
  always_comb begin
    if ((state_r == IDLE) && !reset) begin
      gnt_s = pick_grant_s;
    end else begin
      gnt_s = '0;
    end
  end

  // Pointer moves just past the requester that was served.
  always_comb begin
    if (owner_r == PW'(N_REQ - 1)) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = owner_r + PW'(1);
    end
  end

  // Arbitration FSM with all datapath and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      rr_ptr_r     <= '0;
      owner_r      <= '0;
      op_a_r       <= '0;
      op_b_r       <= '0;
      rsp_result_r <= '0;
      rsp_valid_r  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          rsp_valid_r <= '0;
          if (any_s) begin
            op_a_r  <= sel_a_s;
            op_b_r  <= sel_b_s;
            owner_r <= winner_s;
            state_r <= EXEC;
          end else begin
            state_r <= IDLE;
          end
        end
        EXEC: begin
          // Pulse is raised here so it is visible for exactly the RESP cycle.
          rsp_result_r <= bus.add_result;
          rsp_valid_r  <= N_REQ'(1) << owner_r;
          state_r      <= RESP;
        end
        RESP: begin
          rsp_valid_r <= '0;
          rr_ptr_r    <= next_ptr_s;
          state_r     <= IDLE;
        end
        default: begin
          rsp_valid_r <= '0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt        = gnt_s;
  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_result = rsp_result_r;
  assign bus.add_a      = op_a_r;
  assign bus.add_b      = op_b_r;

endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one combinational 8-bit `adder` instance between N_REQ requesters, for example PC-increment logic and branch-target logic.
- Per requester: a req/gnt handshake, then a registered result with a one-cycle response pulse.
- Round-robin arbitration. The block drives the adder operands and captures the adder result.
- Sits beside the datapath; the adder instance stays outside this block.

Parameters:
- WIDTH, 8, operand/result width in bits; must match the adder.
- N_REQ, 2, number of requesters (2..8).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  N_REQ  request per requester; held high with operands stable until granted.
- req_a  input  N_REQ*WIDTH  operand A per requester; slice i = [i*WIDTH +: WIDTH].
- req_b  input  N_REQ*WIDTH  operand B per requester; same slicing.
- gnt  output  N_REQ  one-hot grant; combinational, asserted only in IDLE.
- rsp_valid  output  N_REQ  one-hot, one-cycle pulse marking rsp_result valid for that requester.
- rsp_result  output  WIDTH  registered sum of the last completed operation.
- add_a  output  WIDTH  operand A to the external adder.
- add_b  output  WIDTH  operand B to the external adder.
- add_result  input  WIDTH  sum from the external adder.

Behaviour:
- Clocking and reset: one clock, clk. reset is asynchronous, active-high.
- Values on reset:
  - state = IDLE, rr_ptr = 0, owner = 0.
  - op_a/op_b regs = 0, rsp_result = 0, rsp_valid = 0.
  - gnt = 0 while reset is asserted.
- add_a/add_b are always driven from the op_a/op_b registers (0 after reset).
- FSM:
  - IDLE:
    - If req != 0, pick a winner by round-robin: first set bit at or after rr_ptr, wrapping from N_REQ-1 to 0.
    - gnt[winner] = 1 combinationally in this cycle.
    - At the clock edge: op_a <= req_a[winner], op_b <= req_b[winner], owner <= winner, go to EXEC.
    - If req == 0: gnt = 0, stay in IDLE.
  - EXEC: rsp_result <= add_result at the edge; go to RESP.
  - RESP:
    - rsp_valid[owner] = 1 (registered pulse, exactly one cycle).
    - rr_ptr <= (owner+1) mod N_REQ.
    - Go to IDLE.
- Latency: gnt cycle = T; rsp_valid and rsp_result valid in cycle T+2. Throughput is one operation per 3 cycles.
- gnt is never asserted outside IDLE. Requests arriving in EXEC/RESP wait.
- A requester may deassert req the cycle after gnt. If req stays high it is treated as a new request and arbitrated fairly.
- Arithmetic: modulo 2^WIDTH; carry is discarded (0xFF + 0x01 = 0x00). The arbiter does no arithmetic itself.
- Simultaneous requests: exactly one gnt bit. The loser keeps its req asserted and is served next, because rr_ptr moves past the winner.
- rsp_result holds its value until the next EXEC capture.
- Reset mid-operation (EXEC or RESP): the operation is aborted and no rsp_valid is issued. The requester must re-request.
- An X/invalid state returns to IDLE (default branch).

Decomposition:
- Package adder_share_pkg holds:
  - localparam WIDTH default (8).
  - State encoding: IDLE = 2'b00, EXEC = 2'b01, RESP = 2'b10.
  - Pointer width function clog2(N_REQ).
- Sub-module rr_pick (parameter N): inputs req[N] and ptr; outputs one-hot grant[N], winner index, any.
  - Purely combinational.
  - Instantiated once in adder_share_arbiter.
- The adder is instantiated at the top level next to this block, not inside it.

Test Plan:
- Single request: reset, then req=2'b01, req_a[0]=0x12, req_b[0]=0x34.
  - Expect gnt=2'b01 in cycle T, add_a/add_b = 0x12/0x34 at T+1.
  - Expect rsp_valid=2'b01 and rsp_result=0x46 at T+2; gnt=0 at T+1 and T+2.
- Wrap-around: req=2'b10, operands 0xFF, 0x01.
  - Expect rsp_valid=2'b10, rsp_result=0x00.
- Contention and fairness: both req held high continuously with distinct operands (0x10+0x01, 0x20+0x02).
  - Expect grants alternating 01,10,01,10 every 3 cycles.
  - Results alternate 0x11, 0x22, each tagged to the correct rsp_valid bit.
- Late arrival: req[1] rises while an op for requester 0 is in EXEC.
  - Expect no gnt until IDLE; then gnt=2'b10 and a correct result.
- Reset mid-op: assert reset in the EXEC cycle.
  - Expect rsp_valid stays 0, rsp_result=0x00 and state IDLE.
  - After release, a fresh request completes normally, with rr_ptr back at 0.
- Idle stability: req=0 for 20 cycles.
  - Expect gnt=0, rsp_valid=0, and add_a/add_b/rsp_result holding their last values.
